// File: rtl/mux_arb_if.sv
// rtl/mux_arb_if.sv - valid/ready bundle between the producers, mux_arb and its consumer
interface mux_arb_if #(
  parameter int W = 4,
  parameter int N = 4
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*W-1:0]  in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_ch;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/mux_arb.sv
// rtl/mux_arb.sv - N-channel arbitrated mux with one-entry registered output
// Define MUX_ARB_RR_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module mux_arb #(
  parameter int W = 4,
  parameter int N = 4
) (
  input logic      clk,
  input logic      rst_n,
  mux_arb_if.slave bus
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic            free;
  logic            accept;
  logic [SELW-1:0] gnt;
  logic [N-1:0]    ready;
  logic [W-1:0]    sel_data;
  logic            out_valid_q;
  logic [W-1:0]    out_data_q;
  logic [SELW-1:0] out_ch_q;

  assign free   = !out_valid_q || bus.out_ready;
  // rst_n gates the grant so in_ready is forced low while reset is held
  assign accept = free && (|bus.in_valid) && rst_n;

`ifdef MUX_ARB_RR_EN
  logic [SELW-1:0] last_q;

  // Lowest requester above last wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) gnt = SELW'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i] && (i > int'(last_q))) gnt = SELW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SELW'(N - 1);
    end else if (accept) begin
      last_q <= gnt;
    end
  end
`else
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) gnt = SELW'(i);
    end
  end
`endif

  always_comb begin
    ready = '0;
    for (int i = 0; i < N; i++) begin
      if (accept && (gnt == SELW'(i))) ready[i] = 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SELW'(i)) sel_data = bus.in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_ch_q    <= gnt;
    end else if (free) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: doc/mux_arb.md
# mux_arb

Parametrised N-channel, W-bit arbitrated multiplexer with valid/ready handshakes and a one-entry registered output stage. It generalises the datapath 2:1 selector. Several producers (factorial datapath result, GPIO input sampler, debug source) share one consumer without an external select line. The block picks one requesting channel per cycle, captures its word, and reports which channel it came from.

## Interface
Parameters:
- `W`, 4, data width per channel in bits (≥1)
- `N`, 4, number of input channels (≥1; need not be a power of two)
- `SELW` is a local parameter, not a port-level parameter: max(1, ceil(log2 N))

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `in_valid`  input  N  bit i: channel i presents a word
- `in_ready`  output  N  bit i: channel i's word is accepted this cycle (at most one bit high)
- `in_data`  input  N*W  channel i occupies bits [i*W +: W]
- `out_valid`  output  1  output register holds a word
- `out_ready`  input  1  consumer accepts the word this cycle
- `out_data`  output  W  held word
- `out_ch`  output  SELW  index of the channel that supplied `out_data`

## Operation
- The output register is free when `out_valid`=0 or (`out_valid`=1 and `out_ready`=1).
- When free and any `in_valid` bit is high:
  - the arbiter grants exactly one channel g;
  - `in_ready[g]` is 1 and all other `in_ready` bits are 0;
  - on the next edge, `out_data`←channel g's data, `out_ch`←g, `out_valid`←1.
- When not free, all `in_ready` bits are 0.
- `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready` and the pointer; it has no path from `in_data`.
- Drain without refill (free, no `in_valid`): `out_valid`←0 at the edge; `out_data` and `out_ch` keep their last value.
- Simultaneous drain and fill in the same cycle: the new word replaces the old with no bubble.
- Round-robin pointer `last` (SELW bits) holds the last granted index.
  - Search starts at `last`+1 and wraps from N-1 to 0. It never wraps at 2^SELW, and never grants an index ≥N.
  - `last` updates to g only on an accepted grant.
- Producers must hold `in_valid` and `in_data` stable until `in_ready`. The block takes no defined action if this is violated.
- N=1: `in_ready[0]` = free; the pointer stays 0.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `out_valid`=0, `out_data`=0, `out_ch`=0;
  - `last`=N-1, so channel 0 wins the first arbitration;
  - `in_ready`=0, forced combinationally during reset.
- Latency: input handshake at edge k → `out_valid`=1 with the data at edge k+1.
- Throughput: one word per cycle while `out_ready` is held at 1.
- Backpressure: with `out_ready`=0 and `out_valid`=1, all outputs hold and all `in_ready` are 0.
- Reset asserted mid-transfer: the held word is discarded and all state returns to reset values immediately. After deassertion, the first grant goes to the lowest requesting index.

## Configuration
- `MUX_ARB_RR_EN` defined: round-robin arbitration as described above.
- `MUX_ARB_RR_EN` undefined:
  - fixed priority: lowest requesting index always wins;
  - the `last` register is not built;
  - all other behaviour and timing are unchanged.

## Test plan
- Reset, then channel 1 requests with `in_data`[7:4]=0x9 and `out_ready`=1 → `in_ready`=4'b0010; next cycle `out_valid`=1, `out_data`=0x9, `out_ch`=1.
- All 4 channels hold valid (data 0xA, 0xB, 0xC, 0xD) with `out_ready`=1.
  - RR build: `out_ch` sequence is 0,1,2,3,0 on consecutive cycles.
  - Fixed build: `out_ch` stays 0.
- N=3, all valid, RR build → `out_ch` sequence is 0,1,2,0,1; index 3 is never granted.
- `out_valid`=1 with `out_ready`=0 for 5 cycles while channel 2 is valid → `in_ready`=0 throughout and `out_data` stable. Raise `out_ready` → channel 2 is accepted in the same cycle, and `out_data` updates on the next edge.
- Assert `rst_n`=0 while `out_valid`=1 and `out_data`=0x5 → `out_valid` and `out_data` go to 0 before the next edge. After release with channels 2 and 3 valid → the first grant is channel 2.
